// File: rtl/pc_sequencer.sv
// Fetch sequencer for the pipelined vector core: drives PC and resolves flag-conditional branches.
// Optional hardware loop counter enabled by defining PC_SEQ_LOOP_EN.
module pc_sequencer #(
    parameter int I    = 32,
    parameter int F    = 2,
    parameter int IW   = 8,
    parameter int PIPE = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [I-1:0] Instr,
    input  logic         FlagsWrite,
    input  logic [F-1:0] ALUFlags,
    output logic [I-1:0] PC,
    output logic         EndFlag,
    output logic         COMFlag,
    output logic         Stall,
    output logic         Busy
);

    localparam int CW = $clog2(PIPE + 1);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        WAIT,
        DRAIN,
        DONE
    } state_t;

    localparam logic [3:0] OP_LOOP    = 4'hA;
    localparam logic [3:0] OP_ENDLOOP = 4'hB;
    localparam logic [3:0] OP_B       = 4'hC;
    localparam logic [3:0] OP_BEQ     = 4'hD;
    localparam logic [3:0] OP_BNE     = 4'hE;
    localparam logic [3:0] OP_END     = 4'hF;

    state_t          state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [I-1:0]    pc_d;
    logic [I-1:0]    br_off, br_off_d;
    logic            br_ne, br_ne_d;
    logic [F-1:0]    flags_q;
    logic            flags_clr;
    logic            end_d;

    logic [3:0]      opcode;
    logic [IW-1:0]   imm_u;
    logic [I-1:0]    offset;
    logic [I-1:0]    pc_inc;
    logic            z_now;
    logic            taken;

    // Instruction fields outside opcode/imm and the N flag are not consumed here.
    logic            unused_bits;
    assign unused_bits = ^{Instr, flags_q};

    assign opcode  = Instr[I-1:I-4];
    assign imm_u   = Instr[9+IW-1:9];
    assign offset  = {{(I-IW){imm_u[IW-1]}}, imm_u} << 2;
    assign pc_inc  = PC + I'(4);
    // Flags written back this very cycle must win over the stored copy.
    assign z_now   = FlagsWrite ? ALUFlags[0] : flags_q[0];
    assign taken   = br_ne ? ~z_now : z_now;
    assign COMFlag = flags_q[0];

`ifdef PC_SEQ_LOOP_EN
    logic [IW-1:0] loop_cnt, loop_cnt_d;
    logic [I-1:0]  loop_pc, loop_pc_d;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
        state_d   = state;
        cnt_d     = cnt;
        pc_d      = PC;
        br_off_d  = br_off;
        br_ne_d   = br_ne;
        end_d     = EndFlag;
        flags_clr = 1'b0;
        Stall     = 1'b0;
        Busy      = 1'b0;
`ifdef PC_SEQ_LOOP_EN
        loop_cnt_d = loop_cnt;
        loop_pc_d  = loop_pc;
`endif
        case (state)
            IDLE: begin
                pc_d = '0;
                if (start) state_d = RUN;
            end
            RUN: begin
                Busy = 1'b1;
                case (opcode)
                    OP_END: begin
                        Stall   = 1'b1;
                        state_d = DRAIN;
                        cnt_d   = CW'(PIPE - 1);
                    end
                    OP_B: pc_d = PC + offset;
                    OP_BEQ, OP_BNE: begin
                        Stall    = 1'b1;
                        state_d  = WAIT;
                        cnt_d    = CW'(PIPE - 1);
                        br_off_d = offset;
                        br_ne_d  = (opcode == OP_BNE);
                    end
`ifdef PC_SEQ_LOOP_EN
                    OP_LOOP: begin
                        loop_cnt_d = (imm_u == '0) ? IW'(1) : imm_u;
                        loop_pc_d  = pc_inc;
                        pc_d       = pc_inc;
                    end
                    OP_ENDLOOP: begin
                        if (loop_cnt > IW'(1)) begin
                            loop_cnt_d = loop_cnt - IW'(1);
                            pc_d       = loop_pc;
                        end else begin
                            loop_cnt_d = '0;
                            pc_d       = pc_inc;
                        end
                    end
`endif
                    default: pc_d = pc_inc;
                endcase
            end
            WAIT: begin
                Busy  = 1'b1;
                Stall = 1'b1;
                if (cnt == '0) begin
                    pc_d    = taken ? PC + br_off : pc_inc;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            DRAIN: begin
                Busy  = 1'b1;
                Stall = 1'b1;
                if (cnt == '0) begin
                    state_d = DONE;
                    end_d   = 1'b1;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            DONE: begin
                if (start) begin
                    state_d   = RUN;
                    pc_d      = '0;
                    end_d     = 1'b0;
                    flags_clr = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            PC      <= '0;
            br_off  <= '0;
            br_ne   <= 1'b0;
            flags_q <= '0;
            EndFlag <= 1'b0;
`ifdef PC_SEQ_LOOP_EN
            loop_cnt <= '0;
            loop_pc  <= '0;
`endif
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            PC      <= pc_d;
            br_off  <= br_off_d;
            br_ne   <= br_ne_d;
            EndFlag <= end_d;
            if (flags_clr)       flags_q <= '0;
            else if (FlagsWrite) flags_q <= ALUFlags;
`ifdef PC_SEQ_LOOP_EN
            loop_cnt <= loop_cnt_d;
            loop_pc  <= loop_pc_d;
`endif
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: expected next-PC values queued per stimulus cycle and popped after the edge.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] Instr;
    logic        FlagsWrite;
    logic [1:0]  ALUFlags;
    logic [31:0] PC;
    logic        EndFlag;
    logic        COMFlag;
    logic        Stall;
    logic        Busy;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          step = 0;
    logic [31:0] exp_q[$];

    pc_sequencer #(.I(32), .F(2), .IW(8), .PIPE(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .Instr      (Instr),
        .FlagsWrite (FlagsWrite),
        .ALUFlags   (ALUFlags),
        .PC         (PC),
        .EndFlag    (EndFlag),
        .COMFlag    (COMFlag),
        .Stall      (Stall),
        .Busy       (Busy)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] NOP_OP = 4'h0;
    localparam logic [3:0] LP_OP  = 4'hA;
    localparam logic [3:0] EL_OP  = 4'hB;
    localparam logic [3:0] B_OP   = 4'hC;
    localparam logic [3:0] BEQ_OP = 4'hD;
    localparam logic [3:0] BNE_OP = 4'hE;
    localparam logic [3:0] END_OP = 4'hF;

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [7:0] imm);
        return {op, 11'b0, imm, 9'b0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One clock of stimulus: drive at negedge, check combinational outputs, queue the
    // expected registered PC, then compare it just after the rising edge.
    task automatic cyc(input logic [31:0] instr, input logic fw, input logic [1:0] fl,
                       input logic st, input logic exp_stall, input logic exp_busy,
                       input logic [31:0] exp_pc);
        logic [31:0] want;
        @(negedge clk);
        Instr = instr; FlagsWrite = fw; ALUFlags = fl; start = st;
        step++;
        #1;
        check($sformatf("stall@%0d", step), {31'b0, Stall}, {31'b0, exp_stall});
        check($sformatf("busy@%0d", step), {31'b0, Busy}, {31'b0, exp_busy});
        exp_q.push_back(exp_pc);
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        check($sformatf("pc@%0d", step), PC, want);
    endtask

    initial begin
        logic [31:0] nop;
        nop = mk(NOP_OP, 8'h00);
        reset = 1'b1; start = 1'b0; Instr = '0; FlagsWrite = 1'b0; ALUFlags = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", PC, 32'h0);
        check("rst_busy", {31'b0, Busy}, 32'h0);
        check("rst_stall", {31'b0, Stall}, 32'h0);
        check("rst_end", {31'b0, EndFlag}, 32'h0);
        check("rst_com", {31'b0, COMFlag}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Idle with start low, then start and straight-line fetch.
        repeat (5) cyc(nop, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0);
        cyc(nop, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 32'd0);
        cyc(nop, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 32'd4);
        cyc(nop, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 32'd8);
        cyc(nop, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 32'd12);
        cyc(nop, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 32'd16);

        // Backward B, then forward B to 20.
        cyc(mk(B_OP, 8'hFE), 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 32'd8);
        cyc(mk(B_OP, 8'h03), 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 32'd20);

        // BEQ at 20, offset 20; Z=1 written only on the last WAIT cycle (bypass).
        cyc(mk(BEQ_OP, 8'h05), 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 32'd20);
        cyc(mk(BEQ_OP, 8'h05), 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 32'd20);
        cyc(mk(BEQ_OP, 8'h05), 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 32'd20);
        cyc(mk(BEQ_OP, 8'h05), 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 32'd20);
        cyc(mk(BEQ_OP, 8'h05), 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 32'd40);
        check("com_after_z1", {31'b0, COMFlag}, 32'h1);

        // Back to 20; BEQ again with stored Z=1 but bypassed Z=0 -> not taken.
        cyc(mk(B_OP, 8'hFB), 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 32'd20);
        cyc(mk(BEQ_OP, 8'h05), 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 32'd20);
        repeat (3) cyc(mk(BEQ_OP, 8'h05), 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 32'd20);
        cyc(mk(BEQ_OP, 8'h05), 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 32'd24);
        check("com_after_z0", {31'b0, COMFlag}, 32'h0);

        // BNE using stored Z=0 -> taken to 24+16.
        cyc(mk(BNE_OP, 8'h04), 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 32'd24);
        repeat (3) cyc(mk(BNE_OP, 8'h04), 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 32'd24);
        cyc(mk(BNE_OP, 8'h04), 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 32'd40);

        // Most negative offset wraps below zero, most positive wraps back over.
        cyc(mk(B_OP, 8'h80), 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 32'hFFFF_FE28);
        cyc(mk(B_OP, 8'h7F), 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 32'd36);
        cyc(mk(B_OP, 8'hFA), 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 32'd12);

        // END at 12: drain with a flag write and an ignored start.
        cyc(mk(END_OP, 8'h00), 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 32'd12);
        cyc(mk(END_OP, 8'h00), 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 32'd12);
        cyc(mk(END_OP, 8'h00), 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 32'd12);
        cyc(mk(END_OP, 8'h00), 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 32'd12);
        cyc(mk(END_OP, 8'h00), 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 32'd12);
        check("end_set", {31'b0, EndFlag}, 32'h1);
        check("com_drain", {31'b0, COMFlag}, 32'h1);
        cyc(nop, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'd12);
        check("end_hold", {31'b0, EndFlag}, 32'h1);
        cyc(nop, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 32'd0);
        check("end_clr", {31'b0, EndFlag}, 32'h0);
        check("com_clr", {31'b0, COMFlag}, 32'h0);

        // From 0 to 2^32-4, then +508 wraps to 0x1F8.
        cyc(mk(B_OP, 8'hFF), 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        cyc(mk(B_OP, 8'h7F), 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 32'h0000_01F8);

        // Reset in the middle of WAIT.
        cyc(mk(BEQ_OP, 8'h01), 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 32'h1F8);
        cyc(mk(BEQ_OP, 8'h01), 1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 32'h1F8);
        check("com_pre_rst", {31'b0, COMFlag}, 32'h1);
        @(negedge clk);
        reset = 1'b1; FlagsWrite = 1'b0;
        @(posedge clk);
        #1;
        check("wrst_pc", PC, 32'h0);
        check("wrst_stall", {31'b0, Stall}, 32'h0);
        check("wrst_busy", {31'b0, Busy}, 32'h0);
        check("wrst_end", {31'b0, EndFlag}, 32'h0);
        check("wrst_com", {31'b0, COMFlag}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        cyc(nop, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0);

        // Loop program: LOOP 3 at 0, body at 4, ENDLOOP at 8, next at 12.
        cyc(nop, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 32'd0);
        cyc(mk(LP_OP, 8'h03), 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 32'd4);
`ifdef PC_SEQ_LOOP_EN
        repeat (2) begin
            cyc(nop, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 32'd8);
            cyc(mk(EL_OP, 8'h00), 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 32'd4);
        end
`endif
        cyc(nop, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 32'd8);
        cyc(mk(EL_OP, 8'h00), 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 32'd12);
        cyc(nop, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 32'd16);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
